// File: rtl/cpu_top.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_top
//  Description : Self-contained 8-bit multicycle CPU. It contains an FSM
//                control unit, a 4x8 register file, an ALU, the PC, two
//                instruction registers and a unified 256x8 instruction/data
//                memory that powers up holding INIT_PROGRAM. Every internal
//                datapath and control signal is exported for observation.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1  rising-edge clock
//    reset       in   1  asynchronous active-low reset
//    memEnable   out  1  memory write enable (MEM state of ST only)
//    memAdr      out  8  memory address = adrSelect ? ir2 : pc
//    memWD       out  8  memory write data = reg[rd]
//    memRD       out  8  combinational read data mem[memAdr]
//    aluoutM     out  8  ALU result registered every cycle
//    aluout      out  8  combinational ALU result
//    pcNext      out  8  pcSelect ? ir2 : aluout
//    pc          out  8  program counter
//    aluIn1      out  8  op1Sel ? reg[rd] : pc
//    aluIn2      out  8  op2Sel ? operandB : 1
//    pcSelect, pcEnable, adrSelect, ir1En, ir2En, op1Sel, op2Sel, regWrite
//                out  1  FSM control signals
//    aluControl  out  3  000 add, 001 sub, 010 and, 011 or
// ============================================================================
module cpu_top #(
    parameter int         MEM_DEPTH = 256,
    parameter logic [7:0] INIT_PROGRAM [0:MEM_DEPTH-1] = '{
        0: 8'h40, 1: 8'h03,     // ADDI R0,3
        2: 8'h44, 3: 8'h01,     // ADDI R1,1
        4: 8'h01, 5: 8'h00,     // ADD  R0,R1
        6: 8'h60, 7: 8'h80,     // ST   R0,[0x80]
        8: 8'hF0, 9: 8'h00,     // HALT
        default: 8'h00
    }
) (
    input  logic       clk,
    input  logic       reset,
    output logic       memEnable,
    output logic [7:0] memAdr,
    output logic [7:0] memWD,
    output logic [7:0] memRD,
    output logic [7:0] aluoutM,
    output logic [7:0] aluout,
    output logic [7:0] pcNext,
    output logic [7:0] pc,
    output logic [7:0] aluIn1,
    output logic [7:0] aluIn2,
    output logic       pcSelect,
    output logic       pcEnable,
    output logic       adrSelect,
    output logic       ir1En,
    output logic       ir2En,
    output logic       op1Sel,
    output logic       op2Sel,
    output logic       regWrite,
    output logic [2:0] aluControl
);

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_ADDI = 4'h4;
    localparam logic [3:0] c_OP_LD   = 4'h5;
    localparam logic [3:0] c_OP_ST   = 4'h6;
    localparam logic [3:0] c_OP_BEQ  = 4'h7;
    localparam logic [3:0] c_OP_JMP  = 4'h8;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;

    typedef enum logic [2:0] {
        S_FETCH1 = 3'd0,
        S_FETCH2 = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_pc;
    logic [7:0] r_ir1;
    logic [7:0] r_ir2;
    logic [7:0] r_aluoutM;
    logic [7:0] r_regs [0:3];

    // Memory is deliberately outside the reset domain: its power-up image is
    // the program, and reset must leave stored data intact.
    logic [7:0] r_mem [0:MEM_DEPTH-1] = INIT_PROGRAM;

    logic [3:0] w_opcode;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic [7:0] w_rd_val;
    logic [7:0] w_rs_val;
    logic       w_use_rs;
    logic [7:0] w_operand_b;
    logic       w_regs_equal;
    logic [7:0] w_reg_wd;

    // ------------------------------------------------------------------------
    // Instruction decode and operand selection
    // ------------------------------------------------------------------------
    assign w_opcode = r_ir1[7:4];
    assign w_rd     = r_ir1[3:2];
    assign w_rs     = r_ir1[1:0];
    assign w_rd_val = r_regs[w_rd];
    assign w_rs_val = r_regs[w_rs];

    // Register-register instructions (ADD/SUB/AND/OR) and BEQ take their
    // second operand from rs; everything else uses the immediate byte.
    assign w_use_rs    = (w_opcode[3:2] == 2'b00) || (w_opcode == c_OP_BEQ);
    assign w_operand_b = w_use_rs ? w_rs_val : r_ir2;

    // Same condition as the SUB result being zero, computed directly from the
    // register file so the branch decision does not loop back through the
    // ALU controls produced by the FSM.
    assign w_regs_equal = (w_rd_val == w_rs_val);

    assign aluIn1 = op1Sel ? w_rd_val : r_pc;
    assign aluIn2 = op2Sel ? w_operand_b : 8'd1;

    always_comb begin
        aluout = 8'h00;
        case (aluControl)
            c_ALU_ADD: aluout = aluIn1 + aluIn2;
            c_ALU_SUB: aluout = aluIn1 - aluIn2;
            c_ALU_AND: aluout = aluIn1 & aluIn2;
            c_ALU_OR:  aluout = aluIn1 | aluIn2;
            default:   aluout = 8'h00;
        endcase
    end

    assign pcNext  = pcSelect ? r_ir2 : aluout;
    assign pc      = r_pc;
    assign aluoutM = r_aluoutM;

    // ------------------------------------------------------------------------
    // Memory: combinational read, synchronous write
    // ------------------------------------------------------------------------
    assign memAdr = adrSelect ? r_ir2 : r_pc;
    assign memRD  = r_mem[memAdr];
    assign memWD  = w_rd_val;

    always_ff @(posedge clk) begin
        if (memEnable) begin
            r_mem[memAdr] <= memWD;
        end
    end

    // Register writeback source: loads come straight from memory in MEM,
    // ALU results come from the registered ALU output in WB.
    assign w_reg_wd = (r_state == S_MEM) ? memRD : r_aluoutM;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= 8'h00;
            r_ir1     <= 8'h00;
            r_ir2     <= 8'h00;
            r_aluoutM <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_aluoutM <= aluout;
            if (pcEnable) begin
                r_pc <= pcNext;
            end
            if (ir1En) begin
                r_ir1 <= memRD;
            end
            if (ir2En) begin
                r_ir2 <= memRD;
            end
            if (regWrite) begin
                r_regs[w_rd] <= w_reg_wd;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        pcSelect     = 1'b0;
        pcEnable     = 1'b0;
        adrSelect    = 1'b0;
        ir1En        = 1'b0;
        ir2En        = 1'b0;
        op1Sel       = 1'b0;
        op2Sel       = 1'b0;
        regWrite     = 1'b0;
        memEnable    = 1'b0;
        aluControl   = c_ALU_ADD;

        case (r_state)
            S_FETCH1: begin
                // pc <= pc + 1 through the ALU while latching the first byte
                ir1En        = 1'b1;
                pcEnable     = 1'b1;
                w_next_state = S_FETCH2;
            end

            S_FETCH2: begin
                ir2En        = 1'b1;
                pcEnable     = 1'b1;
                w_next_state = S_EXEC;
            end

            S_EXEC: begin
                case (w_opcode)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                        op1Sel       = 1'b1;
                        op2Sel       = 1'b1;
                        aluControl   = {1'b0, w_opcode[1:0]};
                        w_next_state = S_WB;
                    end
                    c_OP_ADDI: begin
                        op1Sel       = 1'b1;
                        op2Sel       = 1'b1;
                        aluControl   = c_ALU_ADD;
                        w_next_state = S_WB;
                    end
                    c_OP_LD, c_OP_ST: begin
                        w_next_state = S_MEM;
                    end
                    c_OP_BEQ: begin
                        op1Sel     = 1'b1;
                        op2Sel     = 1'b1;
                        aluControl = c_ALU_SUB;
                        if (w_regs_equal) begin
                            pcSelect = 1'b1;
                            pcEnable = 1'b1;
                        end
                        w_next_state = S_FETCH1;
                    end
                    c_OP_JMP: begin
                        pcSelect     = 1'b1;
                        pcEnable     = 1'b1;
                        w_next_state = S_FETCH1;
                    end
                    c_OP_HALT: begin
                        w_next_state = S_HALT;
                    end
                    default: begin
                        w_next_state = S_FETCH1;
                    end
                endcase
            end

            S_WB: begin
                regWrite     = 1'b1;
                w_next_state = S_FETCH1;
            end

            S_MEM: begin
                adrSelect = 1'b1;
                if (w_opcode == c_OP_ST) begin
                    memEnable = 1'b1;
                end else begin
                    regWrite = 1'b1;
                end
                w_next_state = S_FETCH1;
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_FETCH1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_top
//  Description : Self-checking bench for cpu_top. Four CPU instances run
//                side by side from one clock: the default program, a mixed
//                ALU/branch/store program, a load/store program, and a
//                second copy of the default program that is reset in the
//                middle of its store instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_top;

    localparam int c_N = 4;   // 0 default, 1 alt, 2 load/store, 3 abort

    // ADDI wrap, ST, BEQ taken/not taken, AND/SUB/OR, NOP, JMP, HALT
    localparam logic [7:0] c_ALT_IMAGE [0:255] = '{
        8'h00: 8'h40, 8'h01: 8'hFF,   // ADDI R0,0xFF
        8'h02: 8'h40, 8'h03: 8'h02,   // ADDI R0,2     -> R0 = 0x01
        8'h04: 8'h60, 8'h05: 8'h90,   // ST   R0,[0x90]
        8'h06: 8'h48, 8'h07: 8'h05,   // ADDI R2,5
        8'h08: 8'h4C, 8'h09: 8'h05,   // ADDI R3,5
        8'h0A: 8'h7B, 8'h0B: 8'h20,   // BEQ  R2,R3,0x20 (taken)
        8'h0C: 8'hF0, 8'h0D: 8'h00,   // HALT (only reached if branch fails)
        8'h20: 8'h4C, 8'h21: 8'h01,   // ADDI R3,1     -> R3 = 6
        8'h22: 8'h7B, 8'h23: 8'h30,   // BEQ  R2,R3,0x30 (not taken)
        8'h24: 8'h2B, 8'h25: 8'h00,   // AND  R2,R3    -> R2 = 4
        8'h26: 8'h1E, 8'h27: 8'h00,   // SUB  R3,R2    -> R3 = 2
        8'h28: 8'h3B, 8'h29: 8'h00,   // OR   R2,R3    -> R2 = 6
        8'h2A: 8'h90, 8'h2B: 8'h00,   // opcode 9 = NOP
        8'h2C: 8'h68, 8'h2D: 8'hA0,   // ST   R2,[0xA0]
        8'h2E: 8'h6C, 8'h2F: 8'hA1,   // ST   R3,[0xA1]
        8'h30: 8'h80, 8'h31: 8'h40,   // JMP  0x40
        8'h32: 8'hF0, 8'h33: 8'h00,   // HALT (skipped by JMP)
        8'h40: 8'hF0, 8'h41: 8'h00,   // HALT
        default: 8'h00
    };

    // Default program followed by LD R1,[0x80]; ST R1,[0x81]; HALT
    localparam logic [7:0] c_LDST_IMAGE [0:255] = '{
        8'h00: 8'h40, 8'h01: 8'h03,
        8'h02: 8'h44, 8'h03: 8'h01,
        8'h04: 8'h01, 8'h05: 8'h00,
        8'h06: 8'h60, 8'h07: 8'h80,
        8'h08: 8'h54, 8'h09: 8'h80,   // LD R1,[0x80]
        8'h0A: 8'h64, 8'h0B: 8'h81,   // ST R1,[0x81]
        8'h0C: 8'hF0, 8'h0D: 8'h00,
        default: 8'h00
    };

    logic clk = 1'b0;
    logic r_rst_main;
    logic r_rst_abt;

    wire       w_mem_en  [c_N];
    wire [7:0] w_mem_adr [c_N];
    wire [7:0] w_mem_wd  [c_N];
    wire [7:0] w_mem_rd  [c_N];
    wire [7:0] w_aluoutm [c_N];
    wire [7:0] w_aluout  [c_N];
    wire [7:0] w_pc_next [c_N];
    wire [7:0] w_pc      [c_N];
    wire [7:0] w_alu_in1 [c_N];
    wire [7:0] w_alu_in2 [c_N];
    wire       w_pc_sel  [c_N];
    wire       w_pc_en   [c_N];
    wire       w_adr_sel [c_N];
    wire       w_ir1_en  [c_N];
    wire       w_ir2_en  [c_N];
    wire       w_op1_sel [c_N];
    wire       w_op2_sel [c_N];
    wire       w_reg_wr  [c_N];
    wire [2:0] w_alu_ctl [c_N];

    always #5 clk = ~clk;

    cpu_top u_def (
        .clk(clk), .reset(r_rst_main),
        .memEnable(w_mem_en[0]), .memAdr(w_mem_adr[0]), .memWD(w_mem_wd[0]), .memRD(w_mem_rd[0]),
        .aluoutM(w_aluoutm[0]), .aluout(w_aluout[0]), .pcNext(w_pc_next[0]), .pc(w_pc[0]),
        .aluIn1(w_alu_in1[0]), .aluIn2(w_alu_in2[0]), .pcSelect(w_pc_sel[0]), .pcEnable(w_pc_en[0]),
        .adrSelect(w_adr_sel[0]), .ir1En(w_ir1_en[0]), .ir2En(w_ir2_en[0]), .op1Sel(w_op1_sel[0]),
        .op2Sel(w_op2_sel[0]), .regWrite(w_reg_wr[0]), .aluControl(w_alu_ctl[0])
    );

    cpu_top #(.INIT_PROGRAM(c_ALT_IMAGE)) u_alt (
        .clk(clk), .reset(r_rst_main),
        .memEnable(w_mem_en[1]), .memAdr(w_mem_adr[1]), .memWD(w_mem_wd[1]), .memRD(w_mem_rd[1]),
        .aluoutM(w_aluoutm[1]), .aluout(w_aluout[1]), .pcNext(w_pc_next[1]), .pc(w_pc[1]),
        .aluIn1(w_alu_in1[1]), .aluIn2(w_alu_in2[1]), .pcSelect(w_pc_sel[1]), .pcEnable(w_pc_en[1]),
        .adrSelect(w_adr_sel[1]), .ir1En(w_ir1_en[1]), .ir2En(w_ir2_en[1]), .op1Sel(w_op1_sel[1]),
        .op2Sel(w_op2_sel[1]), .regWrite(w_reg_wr[1]), .aluControl(w_alu_ctl[1])
    );

    cpu_top #(.INIT_PROGRAM(c_LDST_IMAGE)) u_ldst (
        .clk(clk), .reset(r_rst_main),
        .memEnable(w_mem_en[2]), .memAdr(w_mem_adr[2]), .memWD(w_mem_wd[2]), .memRD(w_mem_rd[2]),
        .aluoutM(w_aluoutm[2]), .aluout(w_aluout[2]), .pcNext(w_pc_next[2]), .pc(w_pc[2]),
        .aluIn1(w_alu_in1[2]), .aluIn2(w_alu_in2[2]), .pcSelect(w_pc_sel[2]), .pcEnable(w_pc_en[2]),
        .adrSelect(w_adr_sel[2]), .ir1En(w_ir1_en[2]), .ir2En(w_ir2_en[2]), .op1Sel(w_op1_sel[2]),
        .op2Sel(w_op2_sel[2]), .regWrite(w_reg_wr[2]), .aluControl(w_alu_ctl[2])
    );

    cpu_top u_abt (
        .clk(clk), .reset(r_rst_abt),
        .memEnable(w_mem_en[3]), .memAdr(w_mem_adr[3]), .memWD(w_mem_wd[3]), .memRD(w_mem_rd[3]),
        .aluoutM(w_aluoutm[3]), .aluout(w_aluout[3]), .pcNext(w_pc_next[3]), .pc(w_pc[3]),
        .aluIn1(w_alu_in1[3]), .aluIn2(w_alu_in2[3]), .pcSelect(w_pc_sel[3]), .pcEnable(w_pc_en[3]),
        .adrSelect(w_adr_sel[3]), .ir1En(w_ir1_en[3]), .ir2En(w_ir2_en[3]), .op1Sel(w_op1_sel[3]),
        .op2Sel(w_op2_sel[3]), .regWrite(w_reg_wr[3]), .aluControl(w_alu_ctl[3])
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rel      = 0;
    int rel_abt  = 0;

    int         pcnt [c_N] = '{default: 0};
    int         pcyc [c_N][8];
    logic [7:0] padr [c_N][8];
    logic [7:0] pwd  [c_N][8];
    int         fcnt [c_N] = '{default: 0};
    logic [7:0] fadr [c_N][32];

    logic [7:0] exp_fetch [16] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h20, 8'h22,
                                   8'h24, 8'h26, 8'h28, 8'h2A, 8'h2C, 8'h2E, 8'h30, 8'h40};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {pcSelect, pcEnable, adrSelect, ir1En, ir2En, op1Sel, op2Sel, regWrite, memEnable}
    function automatic logic [8:0] ctrl_vec(input int i);
        return {w_pc_sel[i], w_pc_en[i], w_adr_sel[i], w_ir1_en[i], w_ir2_en[i],
                w_op1_sel[i], w_op2_sel[i], w_reg_wr[i], w_mem_en[i]};
    endfunction

    // Log every store pulse and every FETCH1 address, sampled mid-cycle.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < c_N; i++) begin
            if (((i == 3) ? r_rst_abt : r_rst_main) == 1'b1) begin
                if (w_mem_en[i]) begin
                    if (pcnt[i] < 8) begin
                        pcyc[i][pcnt[i]] = cyc;
                        padr[i][pcnt[i]] = w_mem_adr[i];
                        pwd[i][pcnt[i]]  = w_mem_wd[i];
                    end
                    pcnt[i]++;
                end
                if (w_ir1_en[i]) begin
                    if (fcnt[i] < 32) fadr[i][fcnt[i]] = w_pc[i];
                    fcnt[i]++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        r_rst_main = 1'b0;
        r_rst_abt  = 1'b0;
        repeat (8) @(negedge clk);

        check_value("rst pc",      32'(w_pc[0]),      32'h00);
        check_value("rst ctrl",    32'(ctrl_vec(0)),  32'(9'b010100000));
        check_value("rst aluctl",  32'(w_alu_ctl[0]), 32'h0);
        check_value("rst aluoutM", 32'(w_aluoutm[0]), 32'h00);
        check_value("rst memAdr",  32'(w_mem_adr[0]), 32'h00);
        check_value("rst memRD",   32'(w_mem_rd[0]),  32'h40);
        check_value("rst aluIn2",  32'(w_alu_in2[0]), 32'h01);
        check_value("rst aluout",  32'(w_aluout[0]),  32'h01);
        check_value("rst pcNext",  32'(w_pc_next[0]), 32'h01);

        r_rst_main = 1'b1;
        r_rst_abt  = 1'b1;
        rel        = cyc;

        while (cyc - rel < 120) begin
            @(negedge clk);
            if (cyc - rel == 14) begin
                // u_abt is in EXEC of its ST: abort it here
                check_value("abt exec ctrl", 32'(ctrl_vec(3)),  32'h0);
                check_value("abt exec adr",  32'(w_mem_adr[3]), 32'h08);
                r_rst_abt = 1'b0;
                #1;
                check_value("abt rst pc",   32'(w_pc[3]),     32'h00);
                check_value("abt rst ctrl", 32'(ctrl_vec(3)), 32'(9'b010100000));
            end
            if (cyc - rel == 15) begin
                check_value("def st ctrl", 32'(ctrl_vec(0)),  32'(9'b001000001));
                check_value("def st adr",  32'(w_mem_adr[0]), 32'h80);
                check_value("def st wd",   32'(w_mem_wd[0]),  32'h04);
            end
            if (cyc - rel == 17) begin
                check_value("abt no write", 32'(u_abt.r_mem[8'h80]), 32'h00);
                check_value("abt no pulse", 32'(pcnt[3]),            32'd0);
                r_rst_abt = 1'b1;
                rel_abt   = cyc;
            end
            if (cyc - rel == 40) begin
                check_value("def halt pc early", 32'(w_pc[0]), 32'h0A);
            end
        end

        // default program
        check_value("def pulses",     32'(pcnt[0]),              32'd1);
        check_value("def pulse cyc",  32'(pcyc[0][0] - rel),     32'd15);
        check_value("def halt pc",    32'(w_pc[0]),              32'h0A);
        check_value("def halt ctrl",  32'(ctrl_vec(0)),          32'h0);
        check_value("def mem80",      32'(u_def.r_mem[8'h80]),   32'h04);

        // mixed program
        check_value("alt pulses",  32'(pcnt[1]),    32'd3);
        check_value("alt st0 adr", 32'(padr[1][0]), 32'h90);
        check_value("alt st0 wd",  32'(pwd[1][0]),  32'h01);
        check_value("alt st1 adr", 32'(padr[1][1]), 32'hA0);
        check_value("alt st1 wd",  32'(pwd[1][1]),  32'h06);
        check_value("alt st2 adr", 32'(padr[1][2]), 32'hA1);
        check_value("alt st2 wd",  32'(pwd[1][2]),  32'h02);
        check_value("alt fetches", 32'(fcnt[1]),    32'd16);
        for (int k = 0; k < 16; k++) begin
            check_value($sformatf("alt fetch %0d", k), 32'(fadr[1][k]), 32'(exp_fetch[k]));
        end
        check_value("alt halt pc", 32'(w_pc[1]), 32'h42);

        // load after the default store
        check_value("ldst pulses",  32'(pcnt[2]),             32'd2);
        check_value("ldst st1 adr", 32'(padr[2][1]),          32'h81);
        check_value("ldst st1 wd",  32'(pwd[2][1]),           32'h04);
        check_value("ldst mem81",   32'(u_ldst.r_mem[8'h81]), 32'h04);

        // aborted instance restarted from pc 0
        check_value("abt pulses",    32'(pcnt[3]),              32'd1);
        check_value("abt pulse cyc", 32'(pcyc[3][0] - rel_abt), 32'd15);
        check_value("abt first pc",  32'(fadr[3][0]),           32'h00);
        check_value("abt mem80",     32'(u_abt.r_mem[8'h80]),   32'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
